// File: rtl/mmio_uart_io.sv
// mmio_uart_io: memory-mapped IO page on the shared CPU bus.
// Holds the LED register, a TX FIFO, and an 8N1 UART transmitter. It also
// provides status, overflow and FIFO-level registers and an idle interrupt.
// Register map (byte offsets from IO_BASE):
//   0 LED    R/W
//   1 STATUS R: {4'b0, ovf, empty, full, busy}; W: in_data[3]=1 clears ovf
//   2 TXDATA W: push into the TX FIFO; R: 0
//   3 LEVEL  R: FIFO entry count, zero-extended
//   4+       read 0, writes ignored
module mmio_uart_io #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] IO_BASE    = 16'h8000,
    parameter int                IO_SPAN_W  = 2,
    parameter int                FIFO_DEPTH = 8,
    parameter int                CLK_DIV    = 234
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              r,
    input  logic              w,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        in_data,
    output logic [7:0]        out_data,
    output logic [7:0]        led,
    output logic              tx,
    output logic              irq
);

    // FIFO_DEPTH is a power of two, so the pointers wrap on their own.
    // The count needs one extra bit so it can hold FIFO_DEPTH itself.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BAUD_ZERO = DIV_W'(0);

    // The window compare uses one extra bit so that a window ending
    // at the top of the address space does not wrap to zero.
    localparam logic [ADDR_W:0] BASE_EXT  = {1'b0, IO_BASE};
    localparam logic [ADDR_W:0] LIMIT_EXT = BASE_EXT + (ADDR_W+1)'(2**IO_SPAN_W);

    localparam logic [ADDR_W-1:0] OFS_LED    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFS_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFS_TXDATA = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] OFS_LEVEL  = ADDR_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Bus decode
    logic              sel_s;
    logic              wr_s;
    logic              rd_s;
    logic [ADDR_W-1:0] offset_s;
    logic [7:0]        rd_val_s;

    // Registers visible on the bus
    logic [7:0]        data_r;
    logic [7:0]        led_r;
    logic              ovf_r;
    logic              irq_r;

    // TX FIFO
    logic [7:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_s;
    logic              pop_s;
    logic              accept_s;
    logic              full_s;
    logic              empty_s;

    // Transmitter
    tx_state_t         state_r;
    tx_state_t         state_nxt_s;
    logic [DIV_W-1:0]  baud_r;
    logic [DIV_W-1:0]  baud_nxt_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_nxt_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_nxt_s;
    logic              tx_r;
    logic              tx_nxt_s;
    logic              baud_end_s;
    logic              busy_s;

    // Window select, offset and strobe qualification (a write wins over a read)
    always_comb begin
        sel_s    = ce & ({1'b0, addr} >= BASE_EXT) & ({1'b0, addr} < LIMIT_EXT);
        offset_s = addr - IO_BASE;
        wr_s     = sel_s & w;
        rd_s     = sel_s & r & ~w;
        push_s   = wr_s & (offset_s == OFS_TXDATA);
    end

    // FIFO flags and the push acceptance rule (a full FIFO still accepts during a pop)
    always_comb begin
        full_s   = (count_r == CNT_FULL);
        empty_s  = (count_r == CNT_ZERO);
        accept_s = push_s & (~full_s | pop_s);
        busy_s   = (state_r != ST_IDLE);
    end

    // Read multiplexer for the register map
    always_comb begin
        rd_val_s = 8'h00;
        case (offset_s)
            OFS_LED:    rd_val_s = led_r;
            OFS_STATUS: rd_val_s = {4'b0000, ovf_r, empty_s, full_s, busy_s};
            OFS_TXDATA: rd_val_s = 8'h00;
            OFS_LEVEL:  rd_val_s[CNT_W-1:0] = count_r;
            default:    rd_val_s = 8'h00;
        endcase
    end

    // LED register and the read data register
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r  <= 8'h00;
            data_r <= 8'h00;
        end else begin
            if (wr_s && (offset_s == OFS_LED)) begin
                led_r <= in_data;
            end
            if (rd_s) begin
                data_r <= rd_val_s;
            end
        end
    end

    // Sticky overflow: set by a dropped push, cleared by writing bit 3 of STATUS
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (push_s && full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end else if (wr_s && (offset_s == OFS_STATUS) && in_data[3]) begin
            ovf_r <= 1'b0;
        end
    end

    // FIFO storage; contents are not reset, only the pointers and count are
    always_ff @(posedge clk) begin
        if (accept_s && !rst) begin
            fifo_mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmitter next state, baud counter, bit index, shifter, FIFO pop and tx level
    always_comb begin
        state_nxt_s   = state_r;
        baud_nxt_s    = baud_r + DIV_W'(1);
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;
        baud_end_s    = (baud_r == BAUD_LAST);
        tx_nxt_s      = 1'b1;

        case (state_r)
            ST_IDLE: begin
                baud_nxt_s = BAUD_ZERO;
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_mem_r[rd_ptr_r];
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_nxt_s    = BAUD_ZERO;
                    bit_idx_nxt_s = 3'd0;
                    state_nxt_s   = ST_DATA;
                end else begin
                    state_nxt_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_nxt_s  = BAUD_ZERO;
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        state_nxt_s   = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_nxt_s = BAUD_ZERO;
                    // Chain straight into the next start bit when data is waiting
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = fifo_mem_r[rd_ptr_r];
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                baud_nxt_s  = BAUD_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase

        // tx is registered from the upcoming state so it lines up with state_r
        case (state_nxt_s)
            ST_START: tx_nxt_s = 1'b0;
            ST_DATA:  tx_nxt_s = shift_nxt_s[0];
            ST_STOP:  tx_nxt_s = 1'b1;
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // Transmitter state register and registered tx / irq outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
            irq_r     <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
            irq_r     <= empty_s & ~busy_s;
        end
    end

    assign out_data = (sel_s & oe) ? data_r : 8'bzzzz_zzzz;
    assign led      = led_r;
    assign tx       = tx_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_mmio_uart_io.sv
// Testbench for mmio_uart_io with CLK_DIV=4 and FIFO_DEPTH=8.
// Bus reads and transmitted UART bytes are checked against scoreboard
// queues that are filled when the stimulus is issued.
module tb_mmio_uart_io;

    localparam logic [15:0] BASE    = 16'h8000;
    localparam int          CLK_DIV = 4;
    localparam int          DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        r;
    logic        w;
    logic        oe;
    logic [15:0] addr;
    logic [7:0]  in_data;
    wire  [7:0]  out_data;
    logic [7:0]  led;
    logic        tx;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] exp_rd_q [$];
    bit         exp_z_q  [$];
    string      exp_nm_q [$];
    logic [7:0] exp_tx_q [$];
    int         frame_start_q [$];
    logic       rd_tag = 1'b0;
    logic       mon_en = 1'b0;

    mmio_uart_io #(
        .ADDR_W     (16),
        .IO_BASE    (BASE),
        .IO_SPAN_W  (2),
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .r        (r),
        .w        (w),
        .oe       (oe),
        .addr     (addr),
        .in_data  (in_data),
        .out_data (out_data),
        .led      (led),
        .tx       (tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Cycle counter used for timing checks
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        ce = 1'b1; w = 1'b1; r = 1'b0; addr = a; in_data = d;
        @(posedge clk);
        #1;
        ce = 1'b0; w = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input bit is_z, input string nm);
        @(negedge clk);
        ce = 1'b1; r = 1'b1; w = 1'b0; oe = 1'b1; addr = a;
        exp_rd_q.push_back(e);
        exp_z_q.push_back(is_z);
        exp_nm_q.push_back(nm);
        rd_tag = 1'b1;
        @(posedge clk);
        #2;
        ce = 1'b0; r = 1'b0; oe = 1'b0; rd_tag = 1'b0;
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_tx_q.size() != 0 || irq !== 1'b1) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes still expected, irq=%b", exp_tx_q.size(), irq);
            exp_tx_q.delete();
        end
    endtask

    // Read monitor: a read captured at this edge is visible on out_data just after it
    always begin
        @(posedge clk);
        if (rd_tag) begin
            #1;
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h with no expectation", out_data);
            end else begin
                logic [7:0] e;
                bit         z;
                string      nm;
                e  = exp_rd_q.pop_front();
                z  = exp_z_q.pop_front();
                nm = exp_nm_q.pop_front();
                if (z) begin
                    checks++;
                    if (out_data !== 8'hzz) begin
                        errors++;
                        $display("FAIL %s: got %h expected zz", nm, out_data);
                    end
                end else begin
                    chk(nm, out_data, e);
                end
            end
        end
    end

    // UART monitor: captures 40 samples per frame, checks bit timing and the byte
    initial begin : tx_mon
        logic [39:0] smp;
        logic [7:0]  byte_v;
        bit          shape_ok;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && tx === 1'b0) begin
                frame_start_q.push_back(cyc);
                smp[0] = tx;
                for (int i = 1; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    smp[i] = tx;
                end
                shape_ok = (smp[0] === 1'b0) && (smp[36] === 1'b1);
                for (int j = 0; j < 10; j++) begin
                    for (int k = 1; k < CLK_DIV; k++) begin
                        if (smp[CLK_DIV*j+k] !== smp[CLK_DIV*j]) shape_ok = 1'b0;
                    end
                end
                for (int b = 0; b < 8; b++) byte_v[b] = smp[CLK_DIV*(b+1)];
                chk("frame_shape", {7'b0, shape_ok}, 8'h01);
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %h with no expectation", byte_v);
                end else begin
                    chk("tx_byte", byte_v, exp_tx_q.pop_front());
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int  c0;
        bit  quiet;
        rst = 1'b1; ce = 1'b0; r = 1'b0; w = 1'b0; oe = 1'b0;
        addr = 16'h0000; in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_tx", tx, 8'h01);
        chk("rst_irq", irq, 8'h01);
        chk("rst_led", led, 8'h00);
        @(negedge clk);
        ce = 1'b1; oe = 1'b1; addr = BASE;
        @(posedge clk);
        #1;
        chk("rst_data_reg", out_data, 8'h00);
        ce = 1'b0; oe = 1'b0;
        bus_read(BASE + 16'd1, 8'h04, 1'b0, "rst_status");
        bus_read(BASE + 16'd3, 8'h00, 1'b0, "rst_level");
        mon_en = 1'b1;

        // LED register and window decode
        bus_write(BASE, 8'hA5);
        chk("led_write", led, 8'hA5);
        bus_read(BASE, 8'hA5, 1'b0, "led_read");
        bus_read(BASE - 16'd1, 8'h00, 1'b1, "below_window");
        bus_read(BASE + 16'd4, 8'h00, 1'b1, "above_window");
        bus_read(BASE + 16'd2, 8'h00, 1'b0, "txdata_read");

        // Single frame 0x55: latency, busy, irq timing
        exp_tx_q.push_back(8'h55);
        bus_write(BASE + 16'd2, 8'h55);
        chk("tx_before_pop", tx, 8'h01);
        @(posedge clk);
        #1;
        c0 = cyc;
        chk("tx_start_latency", tx, 8'h00);
        chk("irq_busy", irq, 8'h00);
        bus_read(BASE + 16'd1, 8'h05, 1'b0, "status_busy");
        to_cyc(c0 + 39);
        chk("tx_stop_bit", tx, 8'h01);
        chk("irq_in_stop", irq, 8'h00);
        to_cyc(c0 + 40);
        chk("irq_lag", irq, 8'h00);
        to_cyc(c0 + 41);
        chk("irq_after_frame", irq, 8'h01);

        // Back-to-back bytes: no idle gap between frames
        frame_start_q.delete();
        exp_tx_q.push_back(8'h01);
        exp_tx_q.push_back(8'h02);
        bus_write(BASE + 16'd2, 8'h01);
        bus_write(BASE + 16'd2, 8'h02);
        bus_read(BASE + 16'd3, 8'h01, 1'b0, "level_during_first");
        wait_drain(300);
        chk("b2b_frames", 8'(frame_start_q.size()), 8'd2);
        if (frame_start_q.size() == 2) begin
            chk("b2b_gap", 8'(frame_start_q[1] - frame_start_q[0]), 8'd40);
        end

        // Overflow: 10 pushes, one popped, eight held, last dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_tx_q.push_back(8'h10 + 8'(i));
            bus_write(BASE + 16'd2, 8'h10 + 8'(i));
        end
        bus_read(BASE + 16'd1, 8'h0B, 1'b0, "status_ovf");
        bus_read(BASE + 16'd3, 8'h08, 1'b0, "level_full");
        bus_write(BASE + 16'd1, 8'hF7);
        bus_read(BASE + 16'd1, 8'h0B, 1'b0, "ovf_sticky");
        bus_write(BASE + 16'd1, 8'h08);
        bus_read(BASE + 16'd1, 8'h03, 1'b0, "ovf_cleared");
        wait_drain(1000);

        // Full FIFO with a push landing exactly on the pop edge
        c0 = 0;
        for (int i = 0; i < 9; i++) begin
            exp_tx_q.push_back(8'hC0 + 8'(i));
            bus_write(BASE + 16'd2, 8'hC0 + 8'(i));
            if (i == 0) c0 = cyc;
        end
        bus_read(BASE + 16'd3, 8'h08, 1'b0, "level_prefill");
        bus_read(BASE + 16'd1, 8'h03, 1'b0, "status_prefill");
        to_cyc(c0 + 40);
        exp_tx_q.push_back(8'hC9);
        bus_write(BASE + 16'd2, 8'hC9);
        bus_read(BASE + 16'd1, 8'h03, 1'b0, "status_push_at_pop");
        bus_read(BASE + 16'd3, 8'h08, 1'b0, "level_push_at_pop");
        wait_drain(1000);

        // Reset during data bit 3 aborts the frame and discards the FIFO
        mon_en = 1'b0;
        bus_write(BASE, 8'h3C);
        chk("led_before_rst", led, 8'h3C);
        bus_write(BASE + 16'd2, 8'h96);
        c0 = cyc;
        bus_write(BASE + 16'd2, 8'h77);
        to_cyc(c0 + 18);
        chk("tx_data_bit3", tx, 8'h00);
        chk("irq_before_rst", irq, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_tx", tx, 8'h01);
        chk("rst_mid_irq", irq, 8'h01);
        chk("rst_mid_led", led, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        bus_read(BASE + 16'd3, 8'h00, 1'b0, "level_after_rst");
        bus_read(BASE + 16'd1, 8'h04, 1'b0, "status_after_rst");
        quiet = 1'b1;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) quiet = 1'b0;
        end
        chk("tx_quiet_after_rst", {7'b0, quiet}, 8'h01);

        // Every issued expectation must have been consumed
        chk("rd_queue_empty", 8'(exp_rd_q.size()), 8'd0);
        chk("tx_queue_empty", 8'(exp_tx_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
